// File: rtl/pooling_controller.sv
// Purpose : walks a row-major feature map and drives an external 2x2/stride-2 average-pooling unit window by window.
// Latency : 4 fetch + 1 drain + Lf (pool) + Lc (clear) + 1 write cycles per window; done 1 cycle after the last write.
// Backpr. : stalls in POOL until pool_finish rises and in CLEAR until it falls; start is ignored while a pass is running.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start / busy / done       pass control: start sampled in IDLE, busy during the pass, done is a 1-cycle pulse
//   in_rd_en/in_addr/in_data  input-map read port, data returns exactly 1 cycle after the strobe
//   pool_start/pool_w*        request and window pixels to the pooling unit (pixels frozen while requested)
//   pool_finish/pool_pixel    pooling unit result handshake
//   out_wr_en/out_addr/out_data  output-map write port, one write per window in row-major order

module pooling_controller #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              pool_start,
    output logic [DATA_W-1:0] pool_w00,
    output logic [DATA_W-1:0] pool_w01,
    output logic [DATA_W-1:0] pool_w10,
    output logic [DATA_W-1:0] pool_w11,
    input  logic              pool_finish,
    input  logic [DATA_W-1:0] pool_pixel,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    // Output map geometry. Odd trailing rows/columns of the input are simply never visited.
    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
    localparam bit MAP_EMPTY = (OW == 0) || (OH == 0);

    localparam logic [ADDR_W-1:0] LAST_J   = ADDR_W'((OW > 0) ? OW - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_I   = ADDR_W'((OH > 0) ? OH - 1 : 0);
    localparam logic [ADDR_W-1:0] ROW_LEN  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IMG_W);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_POOL  = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;
    localparam logic [2:0] ST_WRITE = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [1:0]        fetch_k;    // which of the four window pixels is being requested
    logic [ADDR_W-1:0] win_i;
    logic [ADDR_W-1:0] win_j;
    // Running address bases avoid a multiplier: row_base = 2*i*IMG_W, col_base = 2*j.
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col_base;
    // Sequential output index; with j-fastest traversal it always equals i*OW + j.
    logic [ADDR_W-1:0] out_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic              last_win;

    assign last_win = (win_i == LAST_I) && (win_j == LAST_J);

    // k[1] selects the lower row of the window, k[0] the right column.
    assign rd_addr = row_base + col_base
                   + (fetch_k[1] ? ROW_LEN : '0)
                   + {{(ADDR_W-1){1'b0}}, fetch_k[0]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = MAP_EMPTY ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetch_k == 2'd3) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_POOL;
            end
            ST_POOL: begin
                if (pool_finish) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!pool_finish) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = last_win ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            fetch_k  <= 2'd0;
            win_i    <= '0;
            win_j    <= '0;
            row_base <= '0;
            col_base <= '0;
            out_idx  <= '0;
            out_data <= '0;
            pool_w00 <= '0;
            pool_w01 <= '0;
            pool_w10 <= '0;
            pool_w11 <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        fetch_k  <= 2'd0;
                        win_i    <= '0;
                        win_j    <= '0;
                        row_base <= '0;
                        col_base <= '0;
                        out_idx  <= '0;
                    end
                end
                ST_FETCH: begin
                    fetch_k <= fetch_k + 2'd1;
                    // Read data lags the strobe by one cycle, so the pixel
                    // arriving now belongs to the previous request.
                    case (fetch_k)
                        2'd1:    pool_w00 <= in_data;
                        2'd2:    pool_w01 <= in_data;
                        2'd3:    pool_w10 <= in_data;
                        default: ;
                    endcase
                end
                ST_DRAIN: begin
                    pool_w11 <= in_data;
                end
                ST_POOL: begin
                    if (pool_finish) begin
                        out_data <= pool_pixel;
                    end
                end
                ST_WRITE: begin
                    if (!last_win) begin
                        fetch_k <= 2'd0;
                        out_idx <= out_idx + ONE;
                        if (win_j == LAST_J) begin
                            win_j    <= '0;
                            col_base <= '0;
                            win_i    <= win_i + ONE;
                            row_base <= row_base + ROW_STEP;
                        end else begin
                            win_j    <= win_j + ONE;
                            col_base <= col_base + TWO;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the registered state, so a reset clears them
    // on the very next cycle.
    // ------------------------------------------------------------------
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign in_rd_en   = (state_q == ST_FETCH);
    assign in_addr    = (state_q == ST_FETCH) ? rd_addr : '0;
    assign pool_start = (state_q == ST_POOL);
    assign out_wr_en  = (state_q == ST_WRITE);
    assign out_addr   = out_idx;

endmodule

// File: tb/tb_pooling_controller.sv
module tb_pooling_controller;

    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: 4x4 map ----------------
    logic          rst, start, busy, done, in_rd_en, pool_start, pool_finish, out_wr_en;
    logic [AW-1:0] in_addr, out_addr;
    logic [DW-1:0] in_data, pool_w00, pool_w01, pool_w10, pool_w11, pool_pixel, out_data;

    pooling_controller #(.IMG_W(4), .IMG_H(4), .DATA_W(DW), .ADDR_W(AW)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_rd_en(in_rd_en), .in_addr(in_addr), .in_data(in_data),
        .pool_start(pool_start), .pool_w00(pool_w00), .pool_w01(pool_w01),
        .pool_w10(pool_w10), .pool_w11(pool_w11),
        .pool_finish(pool_finish), .pool_pixel(pool_pixel),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data)
    );

    // ---------------- instance B: 5x5 map ----------------
    logic          b_rst, b_start, b_busy, b_done, b_in_rd_en, b_pool_start, b_pool_finish, b_out_wr_en;
    logic [AW-1:0] b_in_addr, b_out_addr;
    logic [DW-1:0] b_in_data, b_pool_w00, b_pool_w01, b_pool_w10, b_pool_w11, b_pool_pixel, b_out_data;

    pooling_controller #(.IMG_W(5), .IMG_H(5), .DATA_W(DW), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
        .in_rd_en(b_in_rd_en), .in_addr(b_in_addr), .in_data(b_in_data),
        .pool_start(b_pool_start), .pool_w00(b_pool_w00), .pool_w01(b_pool_w01),
        .pool_w10(b_pool_w10), .pool_w11(b_pool_w11),
        .pool_finish(b_pool_finish), .pool_pixel(b_pool_pixel),
        .out_wr_en(b_out_wr_en), .out_addr(b_out_addr), .out_data(b_out_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behaviour of the external pooling unit: floor of the signed mean.
    function automatic logic [DW-1:0] pool_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c, input logic [DW-1:0] d);
        logic signed [DW+1:0] s;
        s = $signed({{2{a[DW-1]}}, a}) + $signed({{2{b[DW-1]}}, b})
          + $signed({{2{c[DW-1]}}, c}) + $signed({{2{d[DW-1]}}, d});
        return s[DW+1:2];
    endfunction

    // Stimulus knobs (written only by the main process)
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] b_mem [25];
    int            pool_delay [4];
    bit            clr_rand;

    // Observations (written only by the monitors)
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            runs_q [$];
    int            done_cnt, rd_cnt, run_len;
    bit            prev_wr;
    logic [AW-1:0] b_wr_addr_q [$];
    logic [DW-1:0] b_wr_data_q [$];
    int            b_done_cnt;

    // ---------------- A: input memory, 1-cycle read latency ----------------
    initial begin : mem_model_a
        logic          pend;
        logic [AW-1:0] pa;
        pend = 1'b0; pa = '0; in_data = '0;
        forever begin
            @(negedge clk);
            if (pend) check_eq("a_rd_in_range", pa < 16, 1'b1);
            in_data = (pend && pa < 16) ? mem_a[pa[3:0]] : '0;
            pend = in_rd_en;
            pa   = in_addr;
        end
    end

    // ---------------- A: pooling unit model ----------------
    initial begin : pool_model_a
        int            ph, cnt, hold;
        logic [DW-1:0] sw [4];
        ph = 0; cnt = 0; hold = 0; pool_finish = 1'b0; pool_pixel = '0;
        sw = '{default: '0};
        forever begin
            @(negedge clk);
            if (rst) begin
                ph = 0;
                pool_finish = 1'b0;
            end else begin
                if (ph == 0 && pool_start) begin
                    sw = '{pool_w00, pool_w01, pool_w10, pool_w11};
                    cnt = pool_delay[out_addr[1:0]];
                    hold = 0;
                    ph = 1;
                end
                if (ph == 1) begin
                    hold++;
                    check_eq("a_pool_req_held", pool_start, 1'b1);
                    check_eq("a_window_stable", (pool_w00 == sw[0]) && (pool_w01 == sw[1]) &&
                                                (pool_w10 == sw[2]) && (pool_w11 == sw[3]), 1'b1);
                    check_eq("a_no_write_before_finish", out_wr_en, 1'b0);
                    if (hold >= cnt) begin
                        pool_pixel  = pool_ref(sw[0], sw[1], sw[2], sw[3]);
                        pool_finish = 1'b1;
                        ph = 2;
                    end
                end else if (ph == 2) begin
                    if (!pool_start) begin
                        cnt = clr_rand ? int'($urandom_range(0, 2)) : 0;
                        ph = 3;
                    end
                end
                if (ph == 3) begin
                    if (cnt == 0) begin
                        pool_finish = 1'b0;
                        ph = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // ---------------- A: monitor ----------------
    initial begin : monitor_a
        prev_wr = 1'b0; run_len = 0; done_cnt = 0; rd_cnt = 0;
        forever begin
            @(negedge clk);
            if (in_rd_en) rd_cnt++;
            if (out_wr_en) begin
                wr_addr_q.push_back(out_addr);
                wr_data_q.push_back(out_data);
                check_eq("a_write_excludes_read", in_rd_en, 1'b0);
            end
            if (done) begin
                done_cnt++;
                check_eq("a_done_follows_write", prev_wr, 1'b1);
            end
            if (pool_start) begin
                run_len++;
            end else if (run_len != 0) begin
                runs_q.push_back(run_len);
                run_len = 0;
            end
            prev_wr = out_wr_en;
        end
    end

    // ---------------- B: memory, immediate pooling unit, monitor ----------------
    initial begin : model_b
        logic          bp;
        logic [AW-1:0] bpa;
        int            row, col;
        bp = 1'b0; bpa = '0; b_in_data = '0; b_pool_finish = 1'b0; b_pool_pixel = '0; b_done_cnt = 0;
        forever begin
            @(negedge clk);
            b_in_data = (bp && bpa < 25) ? b_mem[bpa[4:0]] : '0;
            if (b_in_rd_en) begin
                row = int'(b_in_addr) / 5;
                col = int'(b_in_addr) % 5;
                check_eq("b_read_skips_last_row_col", (row < 4) && (col < 4), 1'b1);
            end
            bp  = b_in_rd_en;
            bpa = b_in_addr;
            b_pool_finish = b_pool_start;
            b_pool_pixel  = pool_ref(b_pool_w00, b_pool_w01, b_pool_w10, b_pool_w11);
            if (b_out_wr_en) begin
                b_wr_addr_q.push_back(b_out_addr);
                b_wr_data_q.push_back(b_out_data);
            end
            if (b_done) b_done_cnt++;
        end
    end

    // ---------------- helper tasks (main process) ----------------
    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_rd_en"}, in_rd_en, 1'b0);
        check_eq({tag, "_pool_start"}, pool_start, 1'b0);
        check_eq({tag, "_wr_en"}, out_wr_en, 1'b0);
        check_eq({tag, "_in_addr"}, in_addr, 0);
        check_eq({tag, "_out_addr"}, out_addr, 0);
        check_eq({tag, "_out_data"}, out_data, 0);
        check_eq({tag, "_w00"}, pool_w00, 0);
        check_eq({tag, "_w01"}, pool_w01, 0);
        check_eq({tag, "_w10"}, pool_w10, 0);
        check_eq({tag, "_w11"}, pool_w11, 0);
    endtask

    // Called at a negedge: start is sampled at the following posedge.
    task automatic kick(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy_rise"}, busy, 1'b1);
        check_eq({tag, "_first_rd_en"}, in_rd_en, 1'b1);
        check_eq({tag, "_first_rd_addr"}, in_addr, 0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done_seen"}, done, 1'b1);
    endtask

    // Expected results come straight from the 4x4 memory contents.
    task automatic check_pass(input string tag, input int wb, input int db, input int rb);
        logic [DW-1:0] exp_d [$];
        int            exp_a [$];
        int            r0, c0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                r0 = 2 * i;
                c0 = 2 * j;
                exp_d.push_back(pool_ref(mem_a[r0*4 + c0], mem_a[r0*4 + c0 + 1],
                                         mem_a[(r0+1)*4 + c0], mem_a[(r0+1)*4 + c0 + 1]));
                exp_a.push_back(i * 2 + j);
            end
        end
        check_eq({tag, "_num_writes"}, wr_addr_q.size() - wb, 4);
        for (int k = 0; k < 4; k++) begin
            if (wb + k < wr_addr_q.size()) begin
                check_eq({tag, "_wr_addr"}, wr_addr_q[wb+k], exp_a[k]);
                check_eq({tag, "_wr_data"}, wr_data_q[wb+k], exp_d[k]);
            end
        end
        check_eq({tag, "_done_pulses"}, done_cnt - db, 1);
        check_eq({tag, "_busy_low_after"}, busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (rb + k < runs_q.size()) begin
                check_eq({tag, "_pool_start_len"}, runs_q[rb+k], pool_delay[k]);
            end
        end
    endtask

    task automatic do_pass(input string tag);
        int wb, db, rb;
        wb = wr_addr_q.size();
        db = done_cnt;
        rb = runs_q.size();
        kick(tag);
        wait_done(tag);
        @(negedge clk);
        check_pass(tag, wb, db, rb);
    endtask

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int n, wb, db, rb, rdc, sz;

        rst = 1'b1; start = 1'b0; b_rst = 1'b1; b_start = 1'b0;
        pool_delay = '{1, 1, 1, 1};
        clr_rand = 1'b0;
        for (int p = 0; p < 16; p++) mem_a[p] = DW'(p);
        for (int p = 0; p < 25; p++) b_mem[p] = DW'(p);

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        // Pixels 0..15, immediate finish: results 2, 4, 10, 12
        do_pass("t1_basic");
        check_eq("t1_val0", wr_data_q[wr_data_q.size()-4], 2);
        check_eq("t1_val3", wr_data_q[wr_data_q.size()-1], 12);

        // Slow pooling unit on window 1
        @(negedge clk);
        pool_delay = '{1, 10, 1, 1};
        do_pass("t2_slow_win1");

        // Spurious start while the 2nd window is in flight
        @(negedge clk);
        pool_delay = '{2, 2, 2, 2};
        wb = wr_addr_q.size(); db = done_cnt; rb = runs_q.size();
        kick("t3");
        n = 0;
        while (!(out_addr == 1 && pool_start) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("t3_reach_win1", out_addr == 1 && pool_start, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t3");
        @(negedge clk);
        check_pass("t3_start_ignored", wb, db, rb);

        // Reset during POOL of window 2, then a clean pass
        @(negedge clk);
        pool_delay = '{3, 3, 3, 3};
        kick("t4");
        n = 0;
        while (!(out_addr == 2 && pool_start) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_reach_win2", out_addr == 2 && pool_start, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("t4_after_rst");
        @(negedge clk);
        rst = 1'b0;
        rdc = rd_cnt; sz = wr_addr_q.size(); db = done_cnt;
        repeat (10) @(negedge clk);
        check_eq("t4_no_reads_after_abort", rd_cnt - rdc, 0);
        check_eq("t4_no_writes_after_abort", wr_addr_q.size() - sz, 0);
        check_eq("t4_no_done_after_abort", done_cnt - db, 0);
        do_pass("t4_fresh");

        // Back-to-back passes: second start in the cycle after done
        @(negedge clk);
        pool_delay = '{1, 2, 1, 3};
        do_pass("t5_first");
        do_pass("t5_second");
        sz = wr_data_q.size();
        for (int k = 0; k < 4; k++) begin
            check_eq("t5_same_data", wr_data_q[sz-4+k], wr_data_q[sz-8+k]);
            check_eq("t5_same_addr", wr_addr_q[sz-4+k], wr_addr_q[sz-8+k]);
        end

        // Randomised pixels and handshake latencies
        clr_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            for (int p = 0; p < 16; p++) mem_a[p] = DW'($urandom);
            for (int k = 0; k < 4; k++) pool_delay[k] = int'($urandom_range(1, 6));
            do_pass("t6_random");
        end

        // 5x5 map: odd last row/column never read
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        check_eq("b_busy_rise", b_busy, 1'b1);
        n = 0;
        while (!b_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("b_done_seen", b_done, 1'b1);
        @(negedge clk);
        check_eq("b_num_writes", b_wr_addr_q.size(), 4);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                n = i * 2 + j;
                rb = (2 * i) * 5 + 2 * j;
                if (n < b_wr_addr_q.size()) begin
                    check_eq("b_wr_addr", b_wr_addr_q[n], n);
                    check_eq("b_wr_data", b_wr_data_q[n],
                             pool_ref(b_mem[rb], b_mem[rb+1], b_mem[rb+5], b_mem[rb+6]));
                end
            end
        end
        check_eq("b_done_pulses", b_done_cnt, 1);
        check_eq("b_busy_low_after", b_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
